// File: rtl/if_fetch_unit_pkg.sv
// Shared types and widths for the IF stage: stall/branch bus widths,
// stall encodings and the fetch FSM state type.
package if_fetch_unit_pkg;

    localparam int unsigned STALL_BUS_W = 6;
    localparam int unsigned BR_WD       = 33;
    localparam int unsigned IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_WAIT  = 2'd2,
        IF_VALID = 2'd3
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_npc.sv
// Next-PC select: a pending redirect wins over a same-cycle branch,
// which wins over sequential pc+4.
module if_fetch_unit_npc (
    input  logic [31:0] pc,
    input  logic        redirect_v,
    input  logic [31:0] redirect_pc,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic [31:0] next_pc
);

    always_comb begin
        if (redirect_v) begin
            next_pc = redirect_pc;
        end else if (br_e) begin
            next_pc = br_addr;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues one fetch at a time on a req/addr_ok/data_ok
// SRAM port and holds the fetched word until ID accepts it.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned STALL_W  = STALL_BUS_W,
    parameter int unsigned BR_W     = BR_WD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_W-1:0]        br_bus,
    output logic                   inst_req,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [31:0]            inst_rdata,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic [31:0]            inst_o,
    output logic                   stallreq_if
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        redirect_v_q, redirect_v_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;
    logic        ce;
    logic        advance;
    logic        stall_unused;

    assign br_e         = br_bus[BR_W-1];
    assign br_addr      = br_bus[31:0];
    assign stall_unused = ^stall[STALL_W-1:1];

    if_fetch_unit_npc u_npc (
        .pc          (pc_q),
        .redirect_v  (redirect_v_q),
        .redirect_pc (redirect_pc_q),
        .br_e        (br_e),
        .br_addr     (br_addr),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        redirect_v_d  = redirect_v_q;
        redirect_pc_d = redirect_pc_q;
        inst_req      = 1'b0;
        ce            = 1'b0;
        advance       = 1'b0;

        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                inst_req = 1'b1;
                if (inst_addr_ok) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (inst_data_ok) begin
                    buf_d   = inst_rdata;
                    state_d = IF_VALID;
                end
            end
            IF_VALID: begin
                ce = 1'b1;
                if (stall[0] == NO_STOP) begin
                    advance      = 1'b1;
                    pc_d         = next_pc;
                    redirect_v_d = 1'b0;
                    state_d      = IF_REQ;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        // A branch seen while the PC cannot move is parked until the next advance;
        // this is what lets the delay-slot word issue first.
        if (br_e && !advance) begin
            redirect_pc_d = br_addr;
            redirect_v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            buf_q         <= '0;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            redirect_v_q  <= redirect_v_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign inst_addr    = word_align(pc_q);
    assign if_to_id_bus = ce ? {1'b1, pc_q} : '0;
    assign inst_o       = ce ? buf_q : '0;
    assign stallreq_if  = (state_q != IF_VALID);

endmodule
